// File: rtl/rc4_pkg.sv
// Types and constants shared by the RC4 key-scheduling and PRGA blocks.
package rc4_pkg;

  localparam int S_DEPTH = 256;

  typedef logic [$clog2(S_DEPTH)-1:0] byte_t;

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WR,
    FETCH_I,
    FETCH_J,
    WR_I,
    WR_J,
    FETCH_K,
    XOR_WR
  } prga_state_t;

endpackage

// File: rtl/rc4_prga.sv
// RC4 PRGA + XOR stage: reads a length-prefixed message, permutes S, writes the XORed result.
// Define RC4_PRGA_KEYSTREAM_OUT_EN to expose the keystream as ks_byte / ks_valid.
module rc4_prga
  import rc4_pkg::*;
#(
  parameter int MSG_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  rdy,
  output logic [7:0]            s_addr,
  output logic [7:0]            s_din,
  input  logic [7:0]            s_dout,
  output logic                  s_wren,
  output logic [MSG_ADDR_W-1:0] m_addr,
  input  logic [7:0]            m_dout,
  output logic [MSG_ADDR_W-1:0] c_addr,
  output logic [7:0]            c_din,
  output logic                  c_wren
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
  ,
  output logic [7:0]            ks_byte,
  output logic [0:0]            ks_valid
`endif
);

  prga_state_t           state;
  byte_t                 i, j, si, sj, len;
  logic [MSG_ADDR_W-1:0] k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      si    <= '0;
      sj    <= '0;
      len   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE:    if (en) state <= LEN_RD;
        LEN_RD:  state <= LEN_WR;
        LEN_WR: begin
          len <= m_dout;
          if (m_dout == 8'd0) begin
            state <= IDLE;
          end else begin
            k     <= MSG_ADDR_W'(1);
            i     <= '0;
            j     <= '0;
            state <= FETCH_I;
          end
        end
        FETCH_I: begin
          i     <= i + 8'd1;
          state <= FETCH_J;
        end
        FETCH_J: begin
          si    <= s_dout;
          j     <= j + s_dout;
          state <= WR_I;
        end
        WR_I: begin
          sj    <= s_dout;
          state <= WR_J;
        end
        WR_J:    state <= FETCH_K;
        FETCH_K: state <= XOR_WR;
        XOR_WR: begin
          if (k == MSG_ADDR_W'(len)) begin
            state <= IDLE;
          end else begin
            k     <= k + MSG_ADDR_W'(1);
            state <= FETCH_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rdy = (state == IDLE);

  // RAM-facing outputs are decoded from state because several of them depend on
  // read data returned in the same cycle (j address, S[i] write data, XOR result).
  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    s_addr = '0;
    s_din  = '0;
    s_wren = 1'b0;
    m_addr = '0;
    c_addr = '0;
    c_din  = '0;
    c_wren = 1'b0;
    case (state)
      LEN_WR: begin
        c_din  = m_dout;
        c_wren = 1'b1;
      end
      FETCH_I: s_addr = i + 8'd1;
      FETCH_J: s_addr = j + s_dout;
      WR_I: begin
        s_addr = i;
        s_din  = s_dout;
        s_wren = 1'b1;
      end
      WR_J: begin
        s_addr = j;
        s_din  = si;
        s_wren = 1'b1;
      end
      FETCH_K: begin
        s_addr = si + sj;
        m_addr = k;
      end
      XOR_WR: begin
        c_addr = k;
        c_din  = s_dout ^ m_dout;
        c_wren = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
  assign ks_valid = (state == XOR_WR);
  assign ks_byte  = (state == XOR_WR) ? s_dout : 8'd0;
`endif

endmodule

// File: tb/tb_rc4_prga.sv
// Self-checking bench for rc4_prga: table vectors on identity S, round trip, L=255, reset and busy-en cases.
module tb_rc4_prga;
  import rc4_pkg::*;

  localparam int MSG_ADDR_W = 8;
  localparam int TIMEOUT    = 2000;

  logic                  clk = 1'b0;
  logic                  rst_n, en, rdy;
  logic [7:0]            s_addr, s_din, s_dout;
  logic                  s_wren;
  logic [MSG_ADDR_W-1:0] m_addr, c_addr;
  logic [7:0]            m_dout, c_din;
  logic                  c_wren;
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
  logic [7:0]            ks_byte;
  logic [0:0]            ks_valid;
`endif

  always #5 clk = ~clk;

  rc4_prga #(.MSG_ADDR_W(MSG_ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .s_wren(s_wren),
    .m_addr(m_addr), .m_dout(m_dout),
    .c_addr(c_addr), .c_din(c_din), .c_wren(c_wren)
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
    , .ks_byte(ks_byte), .ks_valid(ks_valid)
`endif
  );

  // RAM models, 1-cycle synchronous read; the bench preloads S through its own port.
  byte_t s_mem [S_DEPTH];
  byte_t m_mem [2**MSG_ADDR_W];
  byte_t c_mem [2**MSG_ADDR_W];
  logic  tb_s_we = 1'b0;
  byte_t tb_s_addr, tb_s_din;

  always @(posedge clk) begin
    if (tb_s_we)     s_mem[tb_s_addr] <= tb_s_din;
    else if (s_wren) s_mem[s_addr]    <= s_din;
    s_dout <= s_mem[s_addr];
    m_dout <= m_mem[m_addr];
    if (c_wren) c_mem[c_addr] <= c_din;
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;

  wr_t         obs_q [$];
  logic [15:0] exp_q [$];
  byte_t       ks_q  [$];
  int          cyc_cnt   = 0;
  int          s_wr_cnt  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (c_wren) obs_q.push_back(wr_t'{c_addr, c_din, cyc_cnt});
    if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
    if (ks_valid == 1'b1) ks_q.push_back(ks_byte);
`endif
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", what, act, exp);
    end
  endtask

  // Reference model state: S contents, message and expected output buffers.
  byte_t ms      [S_DEPTH];
  byte_t msg_buf [2**MSG_ADDR_W];
  byte_t exp_buf [2**MSG_ADDR_W];

  task automatic model_identity();
    for (int n = 0; n < S_DEPTH; n++) ms[n] = byte_t'(n);
  endtask

  task automatic model_ksa_zero_key();
    byte_t jj, t;
    jj = '0;
    model_identity();
    for (int n = 0; n < S_DEPTH; n++) begin
      jj    = jj + ms[n];
      t     = ms[n];
      ms[n] = ms[jj];
      ms[jj] = t;
    end
  endtask

  task automatic model_prga(input int len);
    byte_t ii, jj, t, sum;
    ii = '0;
    jj = '0;
    exp_buf[0] = byte_t'(len);
    for (int n = 1; n <= len; n++) begin
      ii     = ii + 8'd1;
      jj     = jj + ms[ii];
      t      = ms[ii];
      ms[ii] = ms[jj];
      ms[jj] = t;
      sum    = ms[ii] + ms[jj];
      exp_buf[n] = msg_buf[n] ^ ms[sum];
    end
  endtask

  task automatic load_s();
    for (int n = 0; n < S_DEPTH; n++) begin
      @(negedge clk);
      tb_s_we   = 1'b1;
      tb_s_addr = byte_t'(n);
      tb_s_din  = ms[n];
    end
    @(negedge clk);
    tb_s_we = 1'b0;
  endtask

  task automatic prepare(input int len);
    for (int n = 0; n <= len; n++) m_mem[n] = msg_buf[n];
    obs_q.delete();
    exp_q.delete();
    ks_q.delete();
    for (int n = 0; n <= len; n++) exp_q.push_back({8'(n), exp_buf[n]});
  endtask

  task automatic start();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    check("rdy_fall", rdy, 1'b0);
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!rdy && lat < TIMEOUT) begin
      @(posedge clk);
      #1 lat++;
    end
    check("rdy_return", rdy, 1'b1);
  endtask

  // Pop expected writes against observed writes, in order.
  task automatic drain();
    wr_t         o;
    logic [15:0] e;
    int          prev, nk;
    check("write_count", obs_q.size(), exp_q.size());
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
    check("ks_count", ks_q.size(), exp_q.size() - 1);
`endif
    prev = -1;
    nk   = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check("c_addr", o.addr, e[15:8]);
      check("c_din", o.data, e[7:0]);
      if (prev >= 0) check("c_wren_gap", int'(o.cyc) - prev, 6);
      prev = int'(o.cyc);
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
      if (e[15:8] != 8'd0) begin
        if (nk < ks_q.size()) check("ks_byte", ks_q[nk], e[7:0] ^ m_mem[e[15:8]]);
        nk++;
      end
`endif
    end
  endtask

  task automatic do_run(input int len, input int exp_lat);
    int lat;
    prepare(len);
    start();
    wait_rdy(lat);
    check("busy_cycles", lat, exp_lat);
    drain();
  endtask

  typedef struct packed {
    logic [0:3][7:0] m;
    logic [0:3][7:0] c;
    logic [15:0]     lat;
    logic [7:0]      s_diffs;
    logic [7:0]      probe_a;
    logic [7:0]      probe_v;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat, diffs, snap;

    vecs[0] = vec_t'{32'h0100_0000, 32'h0102_0000, 16'd8,  8'd0, 8'd1, 8'd1};
    vecs[1] = vec_t'{32'h0200_0000, 32'h0202_0500, 16'd14, 8'd2, 8'd2, 8'd3};
    vecs[2] = vec_t'{32'h0000_0000, 32'h0000_0000, 16'd2,  8'd0, 8'd0, 8'd0};
    vecs[3] = vec_t'{32'h0341_4243, 32'h0343_4744, 16'd20, 8'd3, 8'd5, 8'd2};

    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("reset_rdy", rdy, 1'b1);
    check("reset_wren", {s_wren, c_wren}, 2'b00);
    check("reset_addr", {s_addr, m_addr, c_addr}, '0);
    check("reset_data", {s_din, c_din}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Identity-S table vectors.
    for (int v = 0; v < 4; v++) begin
      model_identity();
      load_s();
      for (int n = 0; n < 4; n++) begin
        msg_buf[n] = vecs[v].m[n];
        exp_buf[n] = vecs[v].c[n];
      end
      do_run(int'(vecs[v].m[0]), int'(vecs[v].lat));
      diffs = 0;
      for (int n = 0; n < S_DEPTH; n++) if (s_mem[n] != byte_t'(n)) diffs++;
      check("s_diffs", diffs, vecs[v].s_diffs);
      check("s_probe", s_mem[vecs[v].probe_a], vecs[v].probe_v);
    end

    // Round trip through a zero-key KSA permutation.
    model_ksa_zero_key();
    load_s();
    msg_buf[0] = 8'd2;
    msg_buf[1] = 8'h48;
    msg_buf[2] = 8'h69;
    model_prga(2);
    do_run(2, 14);
    model_ksa_zero_key();
    load_s();
    for (int n = 0; n <= 2; n++) msg_buf[n] = c_mem[n];
    exp_buf[0] = 8'd2;
    exp_buf[1] = 8'h48;
    exp_buf[2] = 8'h69;
    do_run(2, 14);

    // Longest message: k must stop at 255 without wrapping.
    model_identity();
    load_s();
    msg_buf[0] = 8'd255;
    for (int n = 1; n <= 255; n++) msg_buf[n] = byte_t'($urandom_range(0, 255));
    model_prga(255);
    do_run(255, 2 + 6 * 255);

    // Back-to-back: S keeps its permutation, i and j restart from zero.
    msg_buf[0] = 8'd3;
    for (int n = 1; n <= 3; n++) msg_buf[n] = byte_t'($urandom_range(0, 255));
    model_prga(3);
    do_run(3, 20);

    // en pulsed while busy is ignored.
    model_identity();
    load_s();
    msg_buf[0] = 8'd1;
    msg_buf[1] = 8'h00;
    exp_buf[0] = 8'd1;
    exp_buf[1] = 8'h02;
    prepare(1);
    start();
    repeat (2) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    wait_rdy(lat);
    check("busy_cycles_en_busy", lat + 3, 8);
    repeat (20) @(posedge clk);
    #1 check("rdy_stays", rdy, 1'b1);
    drain();

    // Reset asserted during WR_J of byte 1.
    model_identity();
    load_s();
    msg_buf[0] = 8'd2;
    msg_buf[1] = 8'h00;
    msg_buf[2] = 8'h00;
    exp_buf[0] = 8'd2;
    prepare(0);
    for (int n = 0; n <= 2; n++) m_mem[n] = msg_buf[n];
    start();
    repeat (5) @(posedge clk);
    #1;
    check("wr_j_wren", s_wren, 1'b1);
    check("wr_j_addr", s_addr, 8'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rdy", rdy, 1'b1);
    check("rst_wren", {s_wren, c_wren}, 2'b00);
    snap = s_wr_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_rdy_after", rdy, 1'b1);
    check("rst_no_s_writes", s_wr_cnt, snap);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
